// File: rtl/instr_asm_pkg.sv
// Shared types for the instruction assembler: FSM state, prefix opcode and
// the FIFO entry carried from the assembler into the output queue.
package instr_asm_pkg;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_PREFIX = 1'b1
  } asm_state_e;

  localparam logic [5:0] PREFIX_OPCODE = 6'b100000;

  typedef struct packed {
    logic [63:0] instr;
    logic [63:0] addr;
    logic        prefixed;
    logic        align_err;
  } fifo_entry_t;

  function automatic logic is_prefix(input logic [31:0] word);
    return word[5:0] == PREFIX_OPCODE;
  endfunction

endpackage

// File: rtl/instr_fifo_if.sv
// Push/pop bus between the assembler FSM (master) and the output queue (slave).
// Handshake: push/pop are single-cycle strobes the master raises only when legal
// (push when count < DEPTH, pop when count != 0); flush overrides both.
interface instr_fifo_if #(
  parameter int DEPTH = 2
);
  logic                             push;
  instr_asm_pkg::fifo_entry_t       push_data;
  logic                             pop;
  logic                             flush;
  instr_asm_pkg::fifo_entry_t       head;
  logic [$clog2(DEPTH):0]           count;

  modport master (output push, push_data, pop, flush, input head, count);
  modport slave  (input push, push_data, pop, flush, output head, count);
endinterface

// File: rtl/instr_fifo.sv
// Synchronous output queue of assembled instructions; the head entry is read
// straight from registered storage so downstream sees no comb path from the input.
module instr_fifo
  import instr_asm_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  instr_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fifo_entry_t   mem_q [DEPTH];
  fifo_entry_t   mem_d [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (bus.push) begin
        mem_d[wr_ptr_q] = bus.push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (bus.pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({bus.push, bus.pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign bus.head  = mem_q[rd_ptr_q];
  assign bus.count = count_q;

endmodule

// File: rtl/instr_assembler.sv
// Joins prefix/suffix fetch words into 64-bit instructions and queues them for
// the Identify stage; a prefix in the last word of a 64-byte block is flagged.
module instr_assembler
  import instr_asm_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic        i_word_valid,
  output logic        o_word_ready,
  input  logic [31:0] i_word,
  input  logic [63:0] i_word_addr,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [63:0] o_instr,
  output logic [63:0] o_instr_addr,
  output logic        o_prefixed,
  output logic        o_align_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  instr_fifo_if #(.DEPTH(DEPTH)) fifo_bus ();

  asm_state_e  state_q, state_d;
  logic [31:0] prefix_q, prefix_d;
  logic [63:0] paddr_q, paddr_d;
  logic        word_acc;
  logic        last_slot;

  assign o_word_ready  = (fifo_bus.count < CW'(DEPTH)) && !i_flush;
  assign word_acc      = i_word_valid && o_word_ready;
  assign last_slot     = i_word_addr[5:2] == 4'hF;
  assign o_instr_valid = fifo_bus.count != '0;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= S_IDLE;
      prefix_q <= '0;
      paddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      prefix_q <= prefix_d;
      paddr_q  <= paddr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    prefix_d = prefix_q;
    paddr_d  = paddr_q;
    if (i_flush) begin
      state_d  = S_IDLE;
      prefix_d = '0;
      paddr_d  = '0;
    end else if (word_acc) begin
      if (state_q == S_PREFIX) begin
        state_d = S_IDLE;
      end else if (is_prefix(i_word) && !last_slot) begin
        state_d  = S_PREFIX;
        prefix_d = i_word;
        paddr_d  = i_word_addr;
      end
    end
  end

  // The suffix word is taken as-is: its opcode is never checked for a prefix.
  always_comb begin
    fifo_bus.push      = 1'b0;
    fifo_bus.push_data = '0;
    if (word_acc) begin
      if (state_q == S_PREFIX) begin
        fifo_bus.push                = 1'b1;
        fifo_bus.push_data.instr     = {i_word, prefix_q};
        fifo_bus.push_data.addr      = paddr_q;
        fifo_bus.push_data.prefixed  = 1'b1;
      end else if (!is_prefix(i_word)) begin
        fifo_bus.push                = 1'b1;
        fifo_bus.push_data.instr     = {32'b0, i_word};
        fifo_bus.push_data.addr      = i_word_addr;
      end else if (last_slot) begin
        fifo_bus.push                = 1'b1;
        fifo_bus.push_data.instr     = {32'b0, i_word};
        fifo_bus.push_data.addr      = i_word_addr;
        fifo_bus.push_data.prefixed  = 1'b1;
        fifo_bus.push_data.align_err = 1'b1;
      end
    end
  end

  assign fifo_bus.pop   = o_instr_valid && i_instr_ready;
  assign fifo_bus.flush = i_flush;

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (fifo_bus.slave)
  );

  // Gate by valid so a flushed queue never shows stale head contents.
  assign o_instr      = o_instr_valid ? fifo_bus.head.instr     : '0;
  assign o_instr_addr = o_instr_valid ? fifo_bus.head.addr      : '0;
  assign o_prefixed   = o_instr_valid ? fifo_bus.head.prefixed  : 1'b0;
  assign o_align_err  = o_instr_valid ? fifo_bus.head.align_err : 1'b0;

endmodule

// File: tb/tb_instr_assembler.sv
// Directed bench for instr_assembler: single words, prefix pairs, block-edge
// prefixes, backpressure, flush and mid-prefix reset.
module tb_instr_assembler;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_word_valid = 1'b0;
  logic        o_word_ready;
  logic [31:0] i_word = '0;
  logic [63:0] i_word_addr = '0;
  logic        o_instr_valid;
  logic        i_instr_ready = 1'b0;
  logic [63:0] o_instr;
  logic [63:0] o_instr_addr;
  logic        o_prefixed;
  logic        o_align_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  instr_assembler #(.DEPTH(2)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_flush       (i_flush),
    .i_word_valid  (i_word_valid),
    .o_word_ready  (o_word_ready),
    .i_word        (i_word),
    .i_word_addr   (i_word_addr),
    .o_instr_valid (o_instr_valid),
    .i_instr_ready (i_instr_ready),
    .o_instr       (o_instr),
    .o_instr_addr  (o_instr_addr),
    .o_prefixed    (o_prefixed),
    .o_align_err   (o_align_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Presents one word for exactly one edge; callers only use it while ready is high.
  task automatic send(input logic [31:0] w, input logic [63:0] a);
    i_word_valid = 1'b1;
    i_word       = w;
    i_word_addr  = a;
    tick();
    i_word_valid = 1'b0;
  endtask

  task automatic pop_one();
    i_instr_ready = 1'b1;
    tick();
    i_instr_ready = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [63:0] instr, input logic [63:0] addr,
                           input logic pre, input logic err);
    check({tag, "_valid"}, 64'(o_instr_valid), 64'd1);
    check({tag, "_instr"}, o_instr, instr);
    check({tag, "_addr"}, o_instr_addr, addr);
    check({tag, "_pre"}, 64'(o_prefixed), 64'(pre));
    check({tag, "_err"}, 64'(o_align_err), 64'(err));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 64'(o_instr_valid), 64'd0);
    check({tag, "_instr"}, o_instr, 64'd0);
    check({tag, "_addr"}, o_instr_addr, 64'd0);
    check({tag, "_pre"}, 64'(o_prefixed), 64'd0);
    check({tag, "_err"}, 64'(o_align_err), 64'd0);
  endtask

  initial begin
    // reset
    #2;
    check_zero("rst");
    repeat (2) tick();
    i_rst = 1'b1;
    tick();
    check_zero("post_rst");
    check("post_rst_ready", 64'(o_word_ready), 64'd1);

    // single non-prefix word
    send(32'h7C0802A6, 64'h1000);
    check_out("single", 64'h00000000_7C0802A6, 64'h1000, 1'b0, 1'b0);
    pop_one();
    check("single_drained", 64'(o_instr_valid), 64'd0);

    // prefix + suffix pair
    send(32'h06000020, 64'h1000);
    check("pair_held", 64'(o_instr_valid), 64'd0);
    send(32'h38600001, 64'h1004);
    check_out("pair", 64'h38600001_06000020, 64'h1000, 1'b1, 1'b0);
    pop_one();
    check("pair_drained", 64'(o_instr_valid), 64'd0);

    // prefix in the last word of a 64-byte block
    send(32'h06000020, 64'h103C);
    check_out("edge", 64'h00000000_06000020, 64'h103C, 1'b1, 1'b1);
    pop_one();
    send(32'h7C0802A6, 64'h1040);
    check_out("after_edge", 64'h00000000_7C0802A6, 64'h1040, 1'b0, 1'b0);
    pop_one();

    // prefix one slot early; suffix has a prefix opcode but is not inspected
    send(32'h06000020, 64'h1038);
    check("late_pre_held", 64'(o_instr_valid), 64'd0);
    send(32'h04000020, 64'h103C);
    check_out("late_pair", 64'h04000020_06000020, 64'h1038, 1'b1, 1'b0);
    pop_one();

    // backpressure: three words offered, two accepted, drained in order
    send(32'h11111111, 64'h2000);
    send(32'h22222222, 64'h2004);
    check("bp_full_ready", 64'(o_word_ready), 64'd0);
    i_word_valid = 1'b1;
    i_word       = 32'h33333333;
    i_word_addr  = 64'h2008;
    tick();
    tick();
    check_out("bp_stable", 64'h00000000_11111111, 64'h2000, 1'b0, 1'b0);
    check("bp_still_full", 64'(o_word_ready), 64'd0);
    i_instr_ready = 1'b1;
    tick();
    check_out("bp_second", 64'h00000000_22222222, 64'h2004, 1'b0, 1'b0);
    tick();
    i_word_valid = 1'b0;
    check_out("bp_third", 64'h00000000_33333333, 64'h2008, 1'b0, 1'b0);
    tick();
    i_instr_ready = 1'b0;
    check("bp_drained", 64'(o_instr_valid), 64'd0);

    // flush with one entry queued and a prefix held
    send(32'h7C0802A6, 64'h2FFC);
    send(32'h06000020, 64'h3000);
    i_flush      = 1'b1;
    i_word_valid = 1'b1;
    i_word       = 32'h38600001;
    i_word_addr  = 64'h3004;
    #1;
    check("flush_ready", 64'(o_word_ready), 64'd0);
    tick();
    i_flush      = 1'b0;
    i_word_valid = 1'b0;
    #1;
    check_zero("flushed");
    send(32'h38600001, 64'h4000);
    check_out("post_flush", 64'h00000000_38600001, 64'h4000, 1'b0, 1'b0);
    pop_one();

    // asynchronous reset while a prefix is held and one entry is queued
    send(32'h7C0802A6, 64'h5000);
    send(32'h06000020, 64'h5004);
    check("pre_rst_valid", 64'(o_instr_valid), 64'd1);
    #2;
    i_rst = 1'b0;
    #1;
    check_zero("mid_rst");
    tick();
    i_rst = 1'b1;
    tick();
    tick();
    check_zero("rst_released");
    send(32'h38600001, 64'h5008);
    check_out("rst_new", 64'h00000000_38600001, 64'h5008, 1'b0, 1'b0);
    pop_one();
    check("final_empty", 64'(o_instr_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
